// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch, data) for one single-port memory.
// Optional fetch starvation guard enabled by defining MEM_ARBITER_STARVE_GUARD_EN.
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DATA = 2'd2
   } own_t;

   own_t rd_own;
   own_t rd_own_next;
   logic force_if;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
      $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
   end

`ifdef MEM_ARBITER_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] streak;

   assign force_if = if_req && (streak == LIMIT);

   // Counts data grants taken while a fetch waits; any fetch grant or idle fetch clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= 4'd0;
      end else if (!if_req || if_gnt) begin
         streak <= 4'd0;
      end else if (d_gnt && (streak != LIMIT)) begin
         streak <= streak + 4'd1;
      end
   end
`else
   assign force_if = 1'b0;
`endif

   always_comb begin
      if_gnt      = 1'b0;
      d_gnt       = 1'b0;
      rd_own_next = OWN_NONE;
      if (!rst) begin
         if (d_req && !force_if) begin
            d_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end
      if (if_gnt) begin
         rd_own_next = OWN_IF;
      end else if (d_gnt && !d_we) begin
         rd_own_next = OWN_DATA;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_own <= OWN_NONE;
      end else begin
         rd_own <= rd_own_next;
      end
   end

   assign mem_address = d_gnt ? d_addr : if_addr;
   assign mem_data    = d_wdata;
   assign mem_wren    = d_gnt & d_we;

   // Gating with rst drops the response of a read that was in flight when reset arrived.
   assign if_rvalid = !rst && (rd_own == OWN_IF);
   assign d_rvalid  = !rst && (rd_own == OWN_DATA);
   assign if_rdata  = mem_q;
   assign d_rdata   = mem_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a read-response scoreboard for mem_arbiter.
`default_nettype none

module tb_mem_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int                due;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t if_q[$];
   exp_t d_q[$];

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   mem_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_gnt(if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata(if_rdata),
      .d_req(d_req),
      .d_we(d_we),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_gnt(d_gnt),
      .d_rvalid(d_rvalid),
      .d_rdata(d_rdata),
      .mem_address(mem_address),
      .mem_data(mem_data),
      .mem_wren(mem_wren),
      .mem_q(mem_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port memory with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_wren) mem[mem_address] <= mem_data;
      mem_q <= mem[mem_address];
   end

   task automatic setin(input logic r, input logic ifr, input logic [ADDR_W-1:0] ifa,
                        input logic dr, input logic dwe, input logic [ADDR_W-1:0] da,
                        input logic [DATA_W-1:0] dwd);
      @(posedge clk);
      #1;
      rst = r; if_req = ifr; if_addr = ifa;
      d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
   endtask

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Checks the combinational grant outputs and queues any expected read response.
   task automatic step(input logic exp_ifg, input logic exp_dg, input logic exp_wren,
                       input logic [ADDR_W-1:0] exp_addr, input logic push,
                       input logic [DATA_W-1:0] exp_rd);
      exp_t e;
      #1;
      chk("if_gnt", 32'(if_gnt), 32'(exp_ifg));
      chk("d_gnt", 32'(d_gnt), 32'(exp_dg));
      chk("mem_wren", 32'(mem_wren), 32'(exp_wren));
      chk("mem_address", 32'(mem_address), 32'(exp_addr));
      e.due  = cyc + 1;
      e.data = exp_rd;
      if (push && exp_ifg) if_q.push_back(e);
      if (push && exp_dg && !d_we) d_q.push_back(e);
   endtask

   // Response monitor: rvalid must appear exactly when a queued response is due.
   initial begin
      forever begin
         @(negedge clk);
         if (if_q.size() > 0 && if_q[0].due == cyc) begin
            chk("if_rvalid", 32'(if_rvalid), 32'd1);
            chk("if_rdata", if_rdata, if_q[0].data);
            void'(if_q.pop_front());
         end else begin
            chk("if_rvalid_idle", 32'(if_rvalid), 32'd0);
         end
         if (d_q.size() > 0 && d_q[0].due == cyc) begin
            chk("d_rvalid", 32'(d_rvalid), 32'd1);
            chk("d_rdata", d_rdata, d_q[0].data);
            void'(d_q.pop_front());
         end else begin
            chk("d_rvalid_idle", 32'(d_rvalid), 32'd0);
         end
      end
   end

   initial begin
      logic g;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
      mem[12'h010] = 32'h0000_0013;
      mem[12'h030] = 32'hA5A5_0001;
      mem[12'h040] = 32'h1234_5678;

      // Requests held during reset are not granted and write nothing.
      setin(1, 1, 12'h010, 1, 1, 12'h020, 32'h1111_1111);
      step(0, 0, 0, 12'h010, 0, 32'h0);
      setin(1, 1, 12'h010, 1, 1, 12'h020, 32'h1111_1111);
      step(0, 0, 0, 12'h010, 0, 32'h0);

      // Fetch granted in the first cycle out of reset.
      setin(0, 1, 12'h010, 0, 0, 12'h000, 32'h0);
      step(1, 0, 0, 12'h010, 1, 32'h0000_0013);

      // Write then read-back of the same address.
      setin(0, 0, 12'h000, 1, 1, 12'h020, 32'hDEAD_BEEF);
      step(0, 1, 1, 12'h020, 1, 32'h0);
      setin(0, 0, 12'h000, 1, 0, 12'h020, 32'h0);
      step(0, 1, 0, 12'h020, 1, 32'hDEAD_BEEF);

      // Data read wins the collision, fetch goes next.
      setin(0, 1, 12'h010, 1, 0, 12'h030, 32'h0);
      step(0, 1, 0, 12'h030, 1, 32'hA5A5_0001);
      setin(0, 1, 12'h010, 0, 0, 12'h030, 32'h0);
      step(1, 0, 0, 12'h010, 1, 32'h0000_0013);

      // Idle: no grant, address follows the fetch port.
      setin(0, 0, 12'h050, 0, 1, 12'h060, 32'h5555_5555);
      step(0, 0, 0, 12'h050, 0, 32'h0);

      // Both held: guard yields D,D,D,D,IF; without it data always wins.
      for (int i = 0; i < 20; i++) begin
         setin(0, 1, 12'h010, 1, 0, 12'h040, 32'h0);
`ifdef MEM_ARBITER_STARVE_GUARD_EN
         g = ((i % 5) == 4);
`else
         g = 1'b0;
`endif
         step(g, !g, 0, g ? 12'h010 : 12'h040, 1, g ? 32'h0000_0013 : 32'h1234_5678);
      end

      // Reset right after a fetch grant cancels its response.
      setin(0, 1, 12'h010, 0, 0, 12'h000, 32'h0);
      step(1, 0, 0, 12'h010, 0, 32'h0);
      setin(1, 1, 12'h010, 0, 0, 12'h000, 32'h0);
      step(0, 0, 0, 12'h010, 0, 32'h0);

      // Write with a fetch waiting, then read it back.
      setin(0, 1, 12'h010, 1, 1, 12'h040, 32'hCAFE_F00D);
      step(0, 1, 1, 12'h040, 1, 32'h0);
      setin(0, 0, 12'h010, 1, 0, 12'h040, 32'h0);
      step(0, 1, 0, 12'h040, 1, 32'hCAFE_F00D);

      setin(0, 0, 12'h000, 0, 0, 12'h000, 32'h0);
      step(0, 0, 0, 12'h000, 0, 32'h0);
      repeat (3) @(posedge clk);
      #2;
      chk("pending_responses", 32'(if_q.size() + d_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
